// File: rtl/sensors_pkg.sv
// -----------------------------------------------------------------------------
// sensors_pkg
// Shared types and helpers for the sequential sensor height aggregator.
//   state_e    : frame FSM states (IDLE/ACCUM/ROUND/OUT)
//   grp_sel_e  : which channel group feeds the rounding divider
//   sum_w()    : accumulator width for n channels of w bits
//   all_shift(): right shift that averages all n channels
//   grp_shift(): right shift that averages one n/2-channel parity group
// -----------------------------------------------------------------------------
package sensors_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_ALL  = 2'd0,  // no faulty channel
    SEL_ODD  = 2'd1,  // an even channel read 0, odd group is clean
    SEL_EVEN = 2'd2,  // an odd channel read 0, even group is clean
    SEL_NONE = 2'd3   // both groups contain a zero, result forced to 0
  } grp_sel_e;

  // Width of the shift-amount bus into the divider; covers any sane channel count.
  localparam int SHIFT_W = 5;

  function automatic int sum_w(input int n, input int w);
    return w + $clog2(n);
  endfunction

  function automatic int all_shift(input int n);
    return $clog2(n);
  endfunction

  function automatic int grp_shift(input int n);
    return $clog2(n) - 1;
  endfunction

  // Priority: clean frame first, then whichever single group is clean.
  function automatic grp_sel_e grp_select(input logic zero_even, input logic zero_odd);
    if (!zero_even && !zero_odd) return SEL_ALL;
    else if (zero_even && !zero_odd) return SEL_ODD;
    else if (zero_odd && !zero_even) return SEL_EVEN;
    else return SEL_NONE;
  endfunction

endpackage

// File: rtl/sensor_round_div.sv
// -----------------------------------------------------------------------------
// sensor_round_div
// Round-half-up right shift: avg_o = (sum_i + 2^(shift_i-1)) >> shift_i, with
// no rounding term when shift_i is 0. The add is one bit wider than the sum so
// the rounding term can never wrap.
// Ports:
//   sum_i   [SUM_W-1:0]    accumulated sum
//   shift_i [SHIFT_W-1:0]  divide-by-power-of-two amount
//   avg_o   [DATA_W-1:0]   rounded quotient
// -----------------------------------------------------------------------------
module sensor_round_div
  import sensors_pkg::*;
#(
  parameter int SUM_W  = 10,
  parameter int DATA_W = 8
) (
  input  logic [SUM_W-1:0]   sum_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [DATA_W-1:0]  avg_o
);

  logic [SUM_W:0] half;
  logic [SUM_W:0] rounded;
  logic           unused_hi;

  // (1 << shift) >> 1 gives 2^(shift-1) for shift >= 1 and 0 for shift == 0.
  assign half    = ({{SUM_W{1'b0}}, 1'b1} << shift_i) >> 1;
  assign rounded = ({1'b0, sum_i} + half) >> shift_i;

  // An average of DATA_W-bit readings always fits in DATA_W bits, so the
  // upper bits of the quotient are zero by construction.
  assign avg_o     = rounded[DATA_W-1:0];
  assign unused_hi = ^rounded[SUM_W:DATA_W];

endmodule

// File: rtl/sensors_aggregator.sv
// -----------------------------------------------------------------------------
// sensors_aggregator
// Accepts a frame of N_SENSORS readings, scans one channel per cycle, treats a
// zero reading as a faulty sensor and emits the round-half-up average of all
// channels, the clean parity group, or 0 when both groups are faulty.
// Optional feature macro: SENSORS_FAULT_FLAG_EN adds fault_mask/no_valid_group.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input frame handshake
//   sensors           channel i at bits [i*DATA_W +: DATA_W]
//   out_valid/out_ready output handshake
//   height            rounded average, held while out_valid is high
//   fault_mask        (macro) bit i set when channel i read 0
//   no_valid_group    (macro) both parity groups contain a zero
// Latency: accept edge T, out_valid high from cycle T+N_SENSORS+2.
// -----------------------------------------------------------------------------
module sensors_aggregator
  import sensors_pkg::*;
#(
  parameter int N_SENSORS = 4,
  parameter int DATA_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_SENSORS*DATA_W-1:0]   sensors,
  output logic                          out_valid,
  input  logic                          out_ready,
`ifdef SENSORS_FAULT_FLAG_EN
  output logic [N_SENSORS-1:0]          fault_mask,
  output logic                          no_valid_group,
`endif
  output logic [DATA_W-1:0]             height
);

  localparam int SUM_W = sum_w(N_SENSORS, DATA_W);
  localparam int IDX_W = $clog2(N_SENSORS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_SENSORS - 1);
  localparam logic [SHIFT_W-1:0] ALL_SH   = SHIFT_W'(all_shift(N_SENSORS));
  localparam logic [SHIFT_W-1:0] GRP_SH   = SHIFT_W'(grp_shift(N_SENSORS));

  state_e                      state_q, state_d;
  logic [N_SENSORS*DATA_W-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [SUM_W-1:0]            sum_all_q, sum_all_d;
  logic [SUM_W-1:0]            sum_even_q, sum_even_d;
  logic [SUM_W-1:0]            sum_odd_q, sum_odd_d;
  logic                        zero_even_q, zero_even_d;
  logic                        zero_odd_q, zero_odd_d;
  logic [DATA_W-1:0]           height_q, height_d;
`ifdef SENSORS_FAULT_FLAG_EN
  logic [N_SENSORS-1:0]        fault_mask_q, fault_mask_d;
  logic                        no_valid_group_q, no_valid_group_d;
`endif

  logic [DATA_W-1:0]  chan [N_SENSORS];
  logic [DATA_W-1:0]  cur;
  logic [SUM_W-1:0]   cur_ext;
  grp_sel_e           sel;
  logic [SUM_W-1:0]   rd_sum;
  logic [SHIFT_W-1:0] rd_shift;
  logic [DATA_W-1:0]  rd_avg;

  // Unpack the registered frame so the scan can index by channel number.
  always_comb begin
    for (int i = 0; i < N_SENSORS; i++) begin
      chan[i] = frame_q[i*DATA_W +: DATA_W];
    end
  end

  assign cur     = chan[idx_q];
  assign cur_ext = {{IDX_W{1'b0}}, cur};

  // Group selection and the single shared divider input mux.
  always_comb begin
    sel      = grp_select(zero_even_q, zero_odd_q);
    rd_sum   = sum_all_q;
    rd_shift = ALL_SH;
    case (sel)
      SEL_ODD: begin
        rd_sum   = sum_odd_q;
        rd_shift = GRP_SH;
      end
      SEL_EVEN: begin
        rd_sum   = sum_even_q;
        rd_shift = GRP_SH;
      end
      default: ;
    endcase
  end

  sensor_round_div #(
    .SUM_W  (SUM_W),
    .DATA_W (DATA_W)
  ) u_round_div (
    .sum_i   (rd_sum),
    .shift_i (rd_shift),
    .avg_o   (rd_avg)
  );

  // NOTE: every next-state signal gets its hold value before the case so that
  // no path through the block leaves one unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    sum_all_d   = sum_all_q;
    sum_even_d  = sum_even_q;
    sum_odd_d   = sum_odd_q;
    zero_even_d = zero_even_q;
    zero_odd_d  = zero_odd_q;
    height_d    = height_q;
`ifdef SENSORS_FAULT_FLAG_EN
    fault_mask_d     = fault_mask_q;
    no_valid_group_d = no_valid_group_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          frame_d     = sensors;
          idx_d       = '0;
          sum_all_d   = '0;
          sum_even_d  = '0;
          sum_odd_d   = '0;
          zero_even_d = 1'b0;
          zero_odd_d  = 1'b0;
          state_d     = ACCUM;
        end
      end

      ACCUM: begin
        sum_all_d = sum_all_q + cur_ext;
        if (idx_q[0]) begin
          sum_odd_d = sum_odd_q + cur_ext;
          if (cur == '0) zero_odd_d = 1'b1;
        end else begin
          sum_even_d = sum_even_q + cur_ext;
          if (cur == '0) zero_even_d = 1'b1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = ROUND;
      end

      ROUND: begin
        height_d = (sel == SEL_NONE) ? '0 : rd_avg;
`ifdef SENSORS_FAULT_FLAG_EN
        for (int i = 0; i < N_SENSORS; i++) begin
          fault_mask_d[i] = (chan[i] == '0);
        end
        no_valid_group_d = zero_even_q & zero_odd_q;
`endif
        state_d = OUT;
      end

      OUT: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others; the frame register is reset
  // along with the control state so nothing stale survives an aborted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      idx_q       <= '0;
      sum_all_q   <= '0;
      sum_even_q  <= '0;
      sum_odd_q   <= '0;
      zero_even_q <= 1'b0;
      zero_odd_q  <= 1'b0;
      height_q    <= '0;
`ifdef SENSORS_FAULT_FLAG_EN
      fault_mask_q     <= '0;
      no_valid_group_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      sum_all_q   <= sum_all_d;
      sum_even_q  <= sum_even_d;
      sum_odd_q   <= sum_odd_d;
      zero_even_q <= zero_even_d;
      zero_odd_q  <= zero_odd_d;
      height_q    <= height_d;
`ifdef SENSORS_FAULT_FLAG_EN
      fault_mask_q     <= fault_mask_d;
      no_valid_group_q <= no_valid_group_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign height    = height_q;
`ifdef SENSORS_FAULT_FLAG_EN
  assign fault_mask     = fault_mask_q;
  assign no_valid_group = no_valid_group_q;
`endif

endmodule

// File: doc/sensors_aggregator.md
# sensors_aggregator

- Parametrised, sequential successor to the combinational four-sensor height averager.
- Accepts one frame of `N_SENSORS` readings over a valid/ready handshake and scans the channels one per cycle.
- Zero readings are treated as faulty sensors; the block selects all channels, the odd-index group or the even-index group, then emits the round-half-up average as `height` over a second valid/ready handshake.
- Sits between the sensor capture logic and the baggage-drop height checker.

## Interface
- `N_SENSORS`, 4, channel count; power of two, ≥2.
- `DATA_W`, 8, bits per reading and per `height`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  frame on `sensors` is valid
- `in_ready`  out  1  block can accept a frame
- `sensors`  in  N_SENSORS*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- `out_valid`  out  1  `height` is valid
- `out_ready`  in  1  downstream accepts `height`
- `height`  out  DATA_W  rounded average
- `fault_mask`  out  N_SENSORS  bit i = channel i read 0 (only with macro)
- `no_valid_group`  out  1  both groups contain a zero (only with macro)

## Operation
- States: IDLE, ACCUM, ROUND, OUT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`: register the full frame; clear all accumulators, zero flags and the index; go to ACCUM.
- **ACCUM**
  - One channel per cycle, index 0..N_SENSORS-1.
  - Adds the reading to `sum_all`, plus `sum_even` or `sum_odd` by index parity.
  - Sets `zero_even` / `zero_odd` when the reading is 0.
  - After index N_SENSORS-1, go to ROUND.
- **ROUND** selects the result in priority order:
  - no zeros: `(sum_all + N/2) >> log2(N)`;
  - else `zero_even`=1 and `zero_odd`=0: `(sum_odd + N/4) >> log2(N/2)`;
  - else `zero_odd`=1 and `zero_even`=0: `(sum_even + N/4) >> log2(N/2)`;
  - else both flags set: result 0.
  - For N_SENSORS=2 the group terms are a single channel with no rounding.
  - Result registered into `height`; go to OUT.
- **OUT**
  - `out_valid`=1; `height` (and fault outputs) held stable.
  - On `out_valid & out_ready`: go to IDLE.
- Arithmetic:
  - Sums are `SUM_W = DATA_W + log2(N_SENSORS)` bits; rounding add is done in SUM_W+1 bits, so there is no truncation.
  - The result never exceeds `2^DATA_W - 1`.
- `sensors` is sampled only at the accept edge; later changes on the bus are ignored.

## Timing
- Reset: state IDLE; `in_ready`=1; `out_valid`=0; `height`=0; `fault_mask`=0; `no_valid_group`=0; accumulators and index 0.
- Accept edge at cycle T. ACCUM occupies T+1..T+N. ROUND at T+N+1. `out_valid` is high from T+N+2.
- `in_ready` is low from T+1 until the cycle after the output handshake.
- Peak throughput: one frame per N_SENSORS+3 cycles (4 sensors: 7).
- Backpressure: `out_valid`/`height` hold indefinitely while `out_ready`=0. `out_ready` may be high before `out_valid`.
- Reset asserted in any state aborts the frame immediately. Outputs return to reset values asynchronously and no partial result is emitted.

## Configuration
- `SENSORS_FAULT_FLAG_EN` defined:
  - `fault_mask` and `no_valid_group` ports exist;
  - both update with `height` in ROUND and are held in OUT.
- Undefined:
  - the ports are absent;
  - fault logic is removed except the zero flags needed for group selection;
  - the both-faulty case still outputs 0.

## Structure
- Shared package `sensors_pkg`:
  - state typedef (IDLE/ACCUM/ROUND/OUT);
  - `SUM_W` and shift-amount helper functions (clog2-based);
  - group-select encoding.
- Sub-module `sensor_round_div`: parametrised round-half-up right shift (in SUM_W, shift amount, out DATA_W). Instantiated once in ROUND with a muxed input sum.

## Test plan
- N=4, W=8, sensors {10,11,12,13} -> sum 46, `height`=12, `out_valid` at T+6.
- {0,20,7,21} -> odd group 41, `height`=21; fault_mask=4'b0001.
- {9,0,10,5} -> even group 19, `height`=10; fault_mask=4'b0010.
- {255,255,255,255} -> `height`=255 (no overflow); {0,0,5,5} -> `height`=0, `no_valid_group`=1, fault_mask=4'b0011.
- `out_ready` low for 5 cycles after `out_valid` -> `height` stable, `in_ready`=0; handshake -> `in_ready`=1 next cycle.
- `rst_n` pulsed low at T+2 mid-ACCUM -> `out_valid` never rises, all outputs reset, next frame {4,4,4,4} -> 4.
